// File: rtl/mips_decode_pipe.sv
// Registered MIPS decoder: decodes the ALU/load/store/SYSCALL subset into a FIFO of control bundles and
// holds intake after a SYSCALL or reserved instruction until that entry has drained and the core acks.
module mips_decode_pipe #(
  parameter int DEPTH     = 2,
  parameter int ALU_SEL_W = 4,
  parameter int REG_W     = 5
) (
  input  logic                 clk,
  input  logic                 rst_b,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_inst,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ALU_SEL_W-1:0] out_alu_sel,
  output logic                 out_alu_src,
  output logic [31:0]          out_imm,
  output logic [REG_W-1:0]     out_rs,
  output logic [REG_W-1:0]     out_rt,
  output logic [REG_W-1:0]     out_dst,
  output logic                 out_we,
  output logic                 out_mem_to_reg,
  output logic                 out_mem_we,
  output logic                 out_sys,
  output logic                 out_ri,
  input  logic                 flush,
  output logic                 exc_pending,
  input  logic                 exc_ack,
  output logic                 exc_is_sys
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  localparam logic [ALU_SEL_W-1:0] ALU_ADD  = ALU_SEL_W'(0);
  localparam logic [ALU_SEL_W-1:0] ALU_ADDU = ALU_SEL_W'(1);
  localparam logic [ALU_SEL_W-1:0] ALU_SUB  = ALU_SEL_W'(2);
  localparam logic [ALU_SEL_W-1:0] ALU_SUBU = ALU_SEL_W'(3);
  localparam logic [ALU_SEL_W-1:0] ALU_AND  = ALU_SEL_W'(4);
  localparam logic [ALU_SEL_W-1:0] ALU_OR   = ALU_SEL_W'(5);
  localparam logic [ALU_SEL_W-1:0] ALU_XOR  = ALU_SEL_W'(6);
  localparam logic [ALU_SEL_W-1:0] ALU_SLT  = ALU_SEL_W'(7);
  localparam logic [ALU_SEL_W-1:0] ALU_SLTU = ALU_SEL_W'(8);

  typedef struct packed {
    logic [ALU_SEL_W-1:0] alu_sel;
    logic                 alu_src;
    logic [31:0]          imm;
    logic [REG_W-1:0]     rs;
    logic [REG_W-1:0]     rt;
    logic [REG_W-1:0]     dst;
    logic                 we;
    logic                 mem_to_reg;
    logic                 mem_we;
    logic                 sys;
    logic                 ri;
  } ctrl_t;

  typedef enum logic [1:0] {RUN, DRAIN, WAIT_ACK} state_t;

  state_t             state;
  ctrl_t              dec;
  ctrl_t              head;
  ctrl_t              mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               accept, pop, i_fmt;
  logic [5:0]         op, funct;
  logic [31:0]        sext, zext;

  assign op     = in_inst[31:26];
  assign funct  = in_inst[5:0];
  assign sext   = {{16{in_inst[15]}}, in_inst[15:0]};
  assign zext   = {16'h0000, in_inst[15:0]};

  always_comb begin
    dec         = '0;
    i_fmt       = 1'b0;
    dec.rs      = REG_W'(in_inst[25:21]);
    dec.rt      = REG_W'(in_inst[20:16]);
    case (op)
      6'h00: begin
        dec.dst = REG_W'(in_inst[15:11]);
        dec.we  = 1'b1;
        case (funct)
          6'h20: dec.alu_sel = ALU_ADD;
          6'h21: dec.alu_sel = ALU_ADDU;
          6'h22: dec.alu_sel = ALU_SUB;
          6'h23: dec.alu_sel = ALU_SUBU;
          6'h24: dec.alu_sel = ALU_AND;
          6'h25: dec.alu_sel = ALU_OR;
          6'h26: dec.alu_sel = ALU_XOR;
          6'h2A: dec.alu_sel = ALU_SLT;
          6'h2B: dec.alu_sel = ALU_SLTU;
          6'h0C: dec.sys     = 1'b1;
          default: dec.ri    = 1'b1;
        endcase
      end
      6'h08: begin i_fmt = 1'b1; dec.alu_sel = ALU_ADD;  dec.imm = sext; end
      6'h09: begin i_fmt = 1'b1; dec.alu_sel = ALU_ADDU; dec.imm = sext; end
      6'h0A: begin i_fmt = 1'b1; dec.alu_sel = ALU_SLT;  dec.imm = sext; end
      6'h0B: begin i_fmt = 1'b1; dec.alu_sel = ALU_SLTU; dec.imm = sext; end
      6'h0C: begin i_fmt = 1'b1; dec.alu_sel = ALU_AND;  dec.imm = zext; end
      6'h0D: begin i_fmt = 1'b1; dec.alu_sel = ALU_OR;   dec.imm = zext; end
      6'h0E: begin i_fmt = 1'b1; dec.alu_sel = ALU_XOR;  dec.imm = zext; end
      6'h0F: begin
        i_fmt       = 1'b1;
        dec.alu_sel = ALU_OR;
        dec.imm     = {in_inst[15:0], 16'h0000};
        dec.rs      = '0;
      end
      6'h23: begin i_fmt = 1'b1; dec.alu_sel = ALU_ADD; dec.imm = sext; dec.mem_to_reg = 1'b1; end
      6'h2B: begin i_fmt = 1'b1; dec.alu_sel = ALU_ADD; dec.imm = sext; dec.mem_we = 1'b1; end
      default: dec.ri = 1'b1;
    endcase
    if (i_fmt) begin
      dec.alu_src = 1'b1;
      dec.dst     = dec.mem_we ? '0 : dec.rt;
      dec.we      = !dec.mem_we;
    end
    if (dec.sys || dec.ri) begin
      dec.we         = 1'b0;
      dec.mem_we     = 1'b0;
      dec.mem_to_reg = 1'b0;
      dec.dst        = '0;
      dec.alu_sel    = ALU_ADD;
    end
    // $zero is never written, so hide the write from the register file
    if (dec.dst == '0) dec.we = 1'b0;
  end

  assign in_ready  = rst_b && (state == RUN) && (count < CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      if (accept && !pop)      count <= count + 1'b1;
      else if (pop && !accept) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept && !flush) mem[wr_ptr] <= dec;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state       <= RUN;
      exc_pending <= 1'b0;
      exc_is_sys  <= 1'b0;
    end else if (flush) begin
      state       <= RUN;
      exc_pending <= 1'b0;
    end else begin
      case (state)
        RUN: if (accept && (dec.sys || dec.ri)) begin
          state      <= DRAIN;
          exc_is_sys <= dec.sys;
        end
        // no intake in DRAIN, so the exception word is the last entry
        DRAIN: if (pop && count == CNT_W'(1)) begin
          state       <= WAIT_ACK;
          exc_pending <= 1'b1;
        end
        WAIT_ACK: if (exc_ack) begin
          state       <= RUN;
          exc_pending <= 1'b0;
        end
        default: state <= RUN;
      endcase
    end
  end

  assign head           = out_valid ? mem[rd_ptr] : '0;
  assign out_alu_sel    = head.alu_sel;
  assign out_alu_src    = head.alu_src;
  assign out_imm        = head.imm;
  assign out_rs         = head.rs;
  assign out_rt         = head.rt;
  assign out_dst        = head.dst;
  assign out_we         = head.we;
  assign out_mem_to_reg = head.mem_to_reg;
  assign out_mem_we     = head.mem_we;
  assign out_sys        = head.sys;
  assign out_ri         = head.ri;
endmodule

// File: tb/tb_mips_decode_pipe.sv
// Directed bench for mips_decode_pipe: table of single-instruction decodes plus hand-written
// sequences for backpressure, SYSCALL/RI drain, flush and asynchronous reset.
module tb_mips_decode_pipe;
  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic [31:0] in_inst = '0;
  logic        out_valid, out_ready = 1'b0;
  logic [3:0]  out_alu_sel;
  logic        out_alu_src;
  logic [31:0] out_imm;
  logic [4:0]  out_rs, out_rt, out_dst;
  logic        out_we, out_mem_to_reg, out_mem_we, out_sys, out_ri;
  logic        flush = 1'b0, exc_pending, exc_ack = 1'b0, exc_is_sys;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [3:0] A_ADD = 4'd0, A_ADDU = 4'd1, A_SUB = 4'd2, A_AND = 4'd4,
                         A_OR = 4'd5, A_XOR = 4'd6, A_SLT = 4'd7, A_SLTU = 4'd8;

  mips_decode_pipe #(.DEPTH(2), .ALU_SEL_W(4), .REG_W(5)) dut (
    .clk(clk), .rst_b(rst_b), .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
    .out_valid(out_valid), .out_ready(out_ready), .out_alu_sel(out_alu_sel),
    .out_alu_src(out_alu_src), .out_imm(out_imm), .out_rs(out_rs), .out_rt(out_rt),
    .out_dst(out_dst), .out_we(out_we), .out_mem_to_reg(out_mem_to_reg),
    .out_mem_we(out_mem_we), .out_sys(out_sys), .out_ri(out_ri), .flush(flush),
    .exc_pending(exc_pending), .exc_ack(exc_ack), .exc_is_sys(exc_is_sys)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [3:0]  alu;
    logic        src;
    logic [31:0] imm;
    logic [4:0]  rs, rt, dst;
    logic        we, m2r, mwe;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ctrl_now();
    return {7'd0, out_alu_sel, out_alu_src, out_rs, out_rt, out_dst,
            out_we, out_mem_to_reg, out_mem_we, out_sys, out_ri};
  endfunction

  function automatic logic [31:0] ctrl_exp(input vec_t v);
    return {7'd0, v.alu, v.src, v.rs, v.rt, v.dst, v.we, v.m2r, v.mwe, 1'b0, 1'b0};
  endfunction

  initial begin
    vecs[0]  = '{32'h2129000A, A_ADD,  1'b1, 32'h0000000A, 5'd9, 5'd9, 5'd9, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{32'h3128FFFF, A_AND,  1'b1, 32'h0000FFFF, 5'd9, 5'd8, 5'd8, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{32'h2128FFFF, A_ADD,  1'b1, 32'hFFFFFFFF, 5'd9, 5'd8, 5'd8, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{32'h3C081234, A_OR,   1'b1, 32'h12340000, 5'd0, 5'd8, 5'd8, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{32'hAD090004, A_ADD,  1'b1, 32'h00000004, 5'd8, 5'd9, 5'd0, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{32'h8D090004, A_ADD,  1'b1, 32'h00000004, 5'd8, 5'd9, 5'd9, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{32'h00221820, A_ADD,  1'b0, 32'h00000000, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{32'h00221822, A_SUB,  1'b0, 32'h00000000, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{32'h0022182B, A_SLTU, 1'b0, 32'h00000000, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{32'h00220021, A_ADDU, 1'b0, 32'h00000000, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{32'h38C58001, A_XOR,  1'b1, 32'h00008001, 5'd6, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{32'h2804FFFE, A_SLT,  1'b1, 32'hFFFFFFFE, 5'd0, 5'd4, 5'd4, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{32'h20000005, A_ADD,  1'b1, 32'h00000005, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{32'h00223825, A_OR,   1'b0, 32'h00000000, 5'd1, 5'd2, 5'd7, 1'b1, 1'b0, 1'b0};

    // reset state
    #12;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_exc", {30'd0, exc_pending, exc_is_sys}, 32'd0);
    chk("rst_ctrl", ctrl_now(), 32'd0);
    chk("rst_imm", out_imm, 32'd0);
    @(negedge clk); rst_b = 1'b1;

    // table: one word at a time, head checked one cycle after acceptance
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_inst = vecs[i].inst; out_ready = 1'b0;
      chk($sformatf("v%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1 in_valid = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d_valid", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("v%0d_ctrl", i), ctrl_now(), ctrl_exp(vecs[i]));
      chk($sformatf("v%0d_imm", i), out_imm, vecs[i].imm);
      out_ready = 1'b1;
      @(posedge clk); #1 out_ready = 1'b0;
    end
    @(negedge clk);
    chk("table_empty", {31'd0, out_valid}, 32'd0);

    // backpressure with DEPTH=2
    in_valid = 1'b1; in_inst = 32'h20010001;
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_ready1", {31'd0, in_ready}, 32'd1);
    in_inst = 32'h20020002;
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_full_ready", {31'd0, in_ready}, 32'd0);
    chk("bp_head1", {27'd0, out_dst}, 32'd1);
    in_inst = 32'h20030003; out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    @(negedge clk);
    chk("bp_ready_after_pop", {31'd0, in_ready}, 32'd1);
    chk("bp_head2", {27'd0, out_dst}, 32'd2);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    chk("bp_full_again", {31'd0, in_ready}, 32'd0);
    chk("bp_head2_hold", {27'd0, out_dst}, 32'd2);
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_head3", {27'd0, out_dst}, 32'd3);
    @(posedge clk); #1 out_ready = 1'b0;
    @(negedge clk);
    chk("bp_empty", {31'd0, out_valid}, 32'd0);

    // SYSCALL drain and acknowledge
    in_valid = 1'b1; in_inst = 32'h0000000C;
    @(posedge clk); #1;
    @(negedge clk);
    chk("sys_in_ready", {31'd0, in_ready}, 32'd0);
    chk("sys_head", {29'd0, out_valid, out_sys, out_we}, 32'b110);
    chk("sys_pending_early", {31'd0, exc_pending}, 32'd0);
    exc_ack = 1'b1;
    @(posedge clk); #1 exc_ack = 1'b0;
    @(negedge clk);
    chk("sys_ack_ignored", {30'd0, in_ready, exc_pending}, 32'd0);
    out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    @(negedge clk);
    chk("sys_wait", {28'd0, out_valid, exc_pending, exc_is_sys, in_ready}, 32'b0110);
    @(posedge clk); #1;
    @(negedge clk);
    chk("sys_wait_hold", {30'd0, exc_pending, in_ready}, 32'b10);
    exc_ack = 1'b1;
    @(posedge clk); #1 begin exc_ack = 1'b0; in_valid = 1'b0; end
    @(negedge clk);
    chk("sys_acked", {30'd0, exc_pending, in_ready}, 32'b01);
    chk("sys_no_repush", {31'd0, out_valid}, 32'd0);

    // reserved instruction, then flush while draining
    in_valid = 1'b1; in_inst = 32'hFC000000;
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    chk("ri_head", {28'd0, out_valid, out_ri, out_we, out_sys}, 32'b1100);
    chk("ri_cause", {30'd0, exc_is_sys, in_ready}, 32'd0);
    flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_state", {29'd0, out_valid, in_ready, exc_pending}, 32'b010);
    @(posedge clk); #1;
    @(negedge clk);
    chk("flush_no_pending", {31'd0, exc_pending}, 32'd0);

    // flush discards a same-cycle accept
    in_valid = 1'b1; in_inst = 32'h2129000A; flush = 1'b1;
    chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1 begin flush = 1'b0; in_valid = 1'b0; end
    @(negedge clk);
    chk("flush_drop_push", {31'd0, out_valid}, 32'd0);

    // SW then asynchronous reset mid-stream
    in_valid = 1'b1; in_inst = 32'hAD090004;
    @(posedge clk); #1;
    @(negedge clk);
    chk("sw_head", {27'd0, out_mem_we, out_we, out_dst}, {27'd0, 1'b1, 1'b0, 5'd0});
    in_inst = 32'h2129000A;
    @(posedge clk); #2 rst_b = 1'b0;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("arst_fields", {30'd0, out_mem_we, out_we}, 32'd0);
    in_valid = 1'b0;
    @(negedge clk); rst_b = 1'b1;
    @(negedge clk);
    chk("post_rst", {30'd0, out_valid, in_ready}, 32'b01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mips_decode_pipe.md
Name: mips_decode_pipe

Overview:
- Registered, parametrised successor to the combinational MIPS decoder.
- Accepts fetched 32-bit instruction words over a valid/ready handshake and decodes the full R-type and I-type ALU, load/store and SYSCALL subset.
- Buffers the decoded control bundles in a DEPTH-entry queue toward execute.
- Runs an exception-drain state machine: after a SYSCALL or reserved instruction, intake stops until execute has consumed it and the core acknowledges.

Parameters:
DEPTH, 2, output queue entries; power of two, >=2
ALU_SEL_W, 4, width of alu_sel; holds the `ALU_* codes from internal_defines.vh
REG_W, 5, register specifier width

Ports:
clk  in  1  clock
rst_b  in  1  asynchronous active-low reset
in_valid  in  1  instruction word valid
in_ready  out  1  block accepts in_inst this cycle
in_inst  in  32  instruction word
out_valid  out  1  head of queue valid
out_ready  in  1  execute consumes head
out_alu_sel  out  ALU_SEL_W  ALU function code
out_alu_src  out  1  1 = immediate operand, 0 = rt
out_imm  out  32  extended immediate
out_rs  out  REG_W  source register rs
out_rt  out  REG_W  source register rt
out_dst  out  REG_W  write register
out_we  out  1  register-file write
out_mem_to_reg  out  1  load
out_mem_we  out  1  store
out_sys  out  1  SYSCALL
out_ri  out  1  reserved instruction
flush  in  1  synchronous queue/state clear
exc_pending  out  1  exception drained, awaiting ack
exc_ack  in  1  core acknowledges exception
exc_is_sys  out  1  pending cause: 1 = SYSCALL, 0 = RI

Behaviour:
- Reset (rst_b low, async):
  - queue count = 0, state = RUN.
  - All out_* = 0, out_valid = 0, in_ready = 0 while rst_b is low.
  - exc_pending = 0, exc_is_sys = 0.
- Accept = in_valid & in_ready. Pop = out_valid & out_ready.
- in_ready = (state == RUN) & (count < DEPTH). No combinational path from out_ready to in_ready.
- out_valid = (count != 0). Head fields are driven from registers; out_* hold their value while out_valid=1 and out_ready=0.
- Latency: an accepted word appears at the head on the next edge when the queue is empty. Order is strictly FIFO.
- Push and pop in the same cycle: count unchanged. Pointers wrap modulo DEPTH.
- Decode, R-type (op 0x00), dst = rd, alu_src = 0, we = 1:
  - funct 0x20 ADD, 0x21 ADDU, 0x22 SUB, 0x23 SUBU, 0x24 AND, 0x25 OR, 0x26 XOR, 0x2A SLT, 0x2B SLTU.
  - funct 0x0C: sys = 1, we = 0.
  - Any other funct: ri = 1, we = 0.
- Decode, I-type, dst = rt, alu_src = 1, we = 1:
  - Sign-extended immediate: 0x08 ADDI, 0x09 ADDIU (ALU_ADD/ADDU), 0x0A SLTI, 0x0B SLTIU.
  - Zero-extended immediate: 0x0C ANDI, 0x0D ORI, 0x0E XORI.
  - 0x0F LUI: imm = {inst[15:0], 16'h0}, ALU_OR with rs forced to 0.
  - 0x23 LW: ALU_ADD, sign-extended, mem_to_reg = 1.
  - 0x2B SW: ALU_ADD, sign-extended, mem_we = 1, we = 0, dst = 0.
- Any other op: ri = 1.
- When sys or ri = 1: we = mem_we = mem_to_reg = 0, dst = 0, alu_sel = ALU_ADD. No X ever leaves the block.
- A write to register 0 is presented as we = 0.
- State machine:
  - RUN -> DRAIN: on accept of a word decoding to sys or ri. Latch exc_is_sys.
  - DRAIN: in_ready = 0. -> WAIT_ACK when the exception entry pops; it is always the last entry.
  - WAIT_ACK: exc_pending = 1, in_ready = 0. -> RUN on exc_ack.
  - exc_ack is ignored in RUN and DRAIN.
- flush (highest priority, synchronous):
  - count = 0, pointers = 0, state = RUN, exc_pending = 0.
  - Any same-cycle accept or pop is discarded; in_ready is still computed normally.
- Reset asserted mid-operation discards all queue contents immediately.

Test Plan:
- Reset, then push 0x2129000A (ADDI $9,$9,10) with out_ready=1 -> next cycle: out_valid=1, alu_sel=ALU_ADD, imm=0x0000000A, dst=9, we=1, alu_src=1.
- Push 0x3128FFFF (ANDI) and 0x2128FFFF (ADDI) -> imm 0x0000FFFF, then 0xFFFFFFFF. Push 0x3C081234 (LUI $8) -> imm 0x12340000, rs=0.
- out_ready=0, push 3 words with DEPTH=2 -> in_ready falls after 2 accepts. Raise out_ready for one cycle with in_valid held -> one pop, then one accept next cycle, order preserved.
- Push 0x0000000C (SYSCALL) then hold in_valid -> in_ready=0. After pop: exc_pending=1, exc_is_sys=1. exc_ack -> in_ready=1.
- Push 0xFC000000 -> ri=1, we=0, exc_is_sys=0. Assert flush while in DRAIN with the entry unpopped -> out_valid=0, state RUN, exc_pending never rises.
- Push SW 0xAD090004 -> mem_we=1, we=0, dst=0. Drop rst_b mid-stream -> out_valid=0 asynchronously, before the next clock edge.
